ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter that shares the single-port synchronous RAM (one address/data/wren/q port) between up to NREQ bus masters: the videocard core(s), the CPU and the loader. Each master issues single-cycle word accesses through a req/gnt handshake. The arbiter muxes the winner onto the RAM port and routes read data back one cycle later. It sits between the masters and the RAM instance at the top level, replacing the direct master-to-RAM wiring.

## Interface
- WIDTH, 32, address and data width (same for both, as on the RAM)
- NREQ, 4, number of requesters, 2..8
- HOLD_MAX, 8, maximum consecutive grants to one owner before forced rotation, ≥1
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- req  in  NREQ  per-master access request, level
- wren_in  in  NREQ  per-master write enable, qualified by req
- address_in  in  NREQ*WIDTH  per-master address, slice i = master i
- data_in  in  NREQ*WIDTH  per-master write data, slice i = master i
- gnt  out  NREQ  one-hot grant; access performed in the cycle req[i]&gnt[i]
- rvalid  out  NREQ  one-hot; read data for master i valid on q_out this cycle
- q_out  out  WIDTH  read data, broadcast to all masters
- ram_address  out  WIDTH  to RAM address
- ram_data  out  WIDTH  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  WIDTH  from RAM q

## Operation
- State: fsm {IDLE, OWN}, owner (log2 NREQ), count (log2 HOLD_MAX + 1), ptr (log2 NREQ), rd_pend, rd_id.
- Grant (combinational from state and req):
  - If OWN, req[owner]=1 and count<HOLD_MAX, then gnt = owner.
  - Otherwise gnt = the first set req scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - If no req is set, gnt = 0.
- Registered updates:
  - New winner w ≠ current owner, or a regrant from IDLE: owner←w, count←1, fsm←OWN.
  - Owner continues: count←count+1.
  - Owner released (drops req, or count=HOLD_MAX): ptr←owner+1 mod NREQ. The next winner is granted in the same cycle, so there is no bubble.
  - No req at all: fsm←IDLE; ptr is unchanged.
- Forced rotation: when count=HOLD_MAX and the owner still requests, the owner is excluded from that cycle's scan. If it is the only requester, it is regranted with count←1. Grants never idle while any req is set.
- RAM mux: ram_address and ram_data are the granted master's slices. ram_wren = |(gnt & req & wren_in). With no grant, the address and data hold their last values and ram_wren=0.
- Read return: a read grant sets rd_pend←1 and rd_id←winner. The following cycle, rvalid[rd_id]=1 and q_out=ram_q. Writes produce no rvalid.

## Timing
- Grant latency is 0 cycles: gnt asserts in the same cycle as req when the master wins.
- Read latency is 1 cycle: rvalid and q_out are valid in the cycle after the grant, because the RAM registers the address.
- Back-to-back reads from the same or different masters run at 1 access per cycle. Each rvalid pulse corresponds 1:1 with its grant.
- Write then read of the same address in the next cycle returns the new data. The RAM is write-before-read across cycles.
- A master must hold address, data and wren stable while req=1 and gnt=0. A master may drop req in any cycle, including the cycle after its grant.
- Reset values:
  - gnt=0, rvalid=0 and ram_wren=0, forced while reset=1.
  - fsm=IDLE, ptr=0, count=0, rd_pend=0, q_out=0, ram_address=0, ram_data=0.
- Reset arriving while a read is pending drops that read's rvalid. No spurious rvalid appears after reset.

## Structure
- Package ram_arb_pkg holds:
  - the fsm state enum;
  - the function clog2;
  - constants IDX_W = clog2(NREQ) and CNT_W = clog2(HOLD_MAX)+1.
- Sub-module rr_picker: a combinational one-hot round-robin picker taking inputs (req, ptr, mask) and producing (gnt, idx). It is instantiated once.
- The top module holds the fsm, the counters, the mux and the read-return pipeline.

## Test plan
- Reset mid-read: master 1 reads, and reset asserts in the following cycle. Required: no rvalid, all outputs at their reset values, and the first grant after reset goes to master 0.
- Single master: master 0 writes 0xDEADBEEF to 0x10, then reads 0x10. Required: gnt in the same cycles; ram_wren=1 on the write only; rvalid[0]=1 one cycle after the read grant with q_out=0xDEADBEEF.
- Contention: all 4 masters hold req from reset release, with HOLD_MAX=1. Required grant order 0,1,2,3,0,… at one grant per cycle, and each rvalid[i] one cycle after gnt[i].
- Hold limit: masters 0 and 2 request continuously, with HOLD_MAX=8. Required: master 0 gets 8 consecutive grants, then master 2 gets 8, with no idle cycle between them.
- Sole requester at the limit: master 3 requests alone for 20 cycles. Required: a grant every cycle, with count wrapping to 1 after 8.
- Release and wrap: master 3 owns the port and drops req while masters 0 and 1 request. Required: the next grant goes to master 0 (ptr wraps 3→0), in the same cycle that master 3 releases.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg : shared types, sizing helper and default widths for ram_arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Number of bits needed to index 'value' items; 1 -> 0, 2 -> 1, 4 -> 2, 8 -> 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NREQ_DEF     = 4;
  localparam int HOLD_MAX_DEF = 8;
  localparam int IDX_W        = clog2(NREQ_DEF);
  localparam int CNT_W        = clog2(HOLD_MAX_DEF) + 1;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker : combinational one-hot round-robin picker, first eligible from ptr
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = IDX_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] eligible;
  logic [IW:0]     cand;

  assign eligible = req & mask;

  // Walk the scan order backwards so the candidate closest to ptr wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int s = NREQ - 1; s >= 0; s--) begin
      cand = {1'b0, ptr} + (IW+1)'(s);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (eligible[cand[IW-1:0]]) begin
        gnt                 = '0;
        gnt[cand[IW-1:0]]   = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter : round-robin sharing of one single-port synchronous RAM
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wren_in,
  input  logic [NREQ*WIDTH-1:0] address_in,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      q_out,
  output logic [WIDTH-1:0]      ram_address,
  output logic [WIDTH-1:0]      ram_data,
  output logic                  ram_wren,
  input  logic [WIDTH-1:0]      ram_q
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(HOLD_MAX) + 1;
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      count_q, count_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               rd_pend_q, rd_pend_d;
  logic [IW-1:0]      rd_id_q, rd_id_d;
  logic [WIDTH-1:0]   last_addr_q, last_data_q;

  logic [WIDTH-1:0]   addr_arr [NREQ];
  logic [WIDTH-1:0]   data_arr [NREQ];
  logic               own_req, keep, force_rot, granted;
  logic [NREQ-1:0]    mask, pick_gnt, win_gnt;
  logic [IW-1:0]      pick_idx, win_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_arr[i] = address_in[i*WIDTH +: WIDTH];
    assign data_arr[i] = data_in[i*WIDTH +: WIDTH];
  end

  assign own_req   = (state_q == OWN) && req[owner_q];
  assign keep      = own_req && (count_q < HOLD_C);
  assign force_rot = own_req && (count_q >= HOLD_C);
  // At the hold limit the owner sits out the scan so others get a turn.
  assign mask      = force_rot ? ~(NREQ'(1) << owner_q) : {NREQ{1'b1}};

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .mask (mask),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    win_idx = pick_idx;
    win_gnt = pick_gnt;
    if (keep || (force_rot && (pick_gnt == '0))) begin
      win_idx = owner_q;
      win_gnt = NREQ'(1) << owner_q;
    end
    if (reset) win_gnt = '0;
  end

  assign gnt         = win_gnt;
  assign granted     = |win_gnt;
  assign ram_wren    = |(win_gnt & req & wren_in);
  assign ram_address = granted ? addr_arr[win_idx] : last_addr_q;
  assign ram_data    = granted ? data_arr[win_idx] : last_data_q;
  assign rvalid      = (rd_pend_q && !reset) ? (NREQ'(1) << rd_id_q) : '0;
  assign q_out       = (rd_pend_q && !reset) ? ram_q : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    rd_pend_d = granted && !wren_in[win_idx];
    rd_id_d   = win_idx;
    if (req == '0) begin
      state_d = IDLE;
    end else if (keep) begin
      count_d = count_q + 1'b1;
    end else begin
      if (state_q == OWN)
        ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      owner_d = win_idx;
      count_d = CW'(1);
      state_d = OWN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
      last_addr_q <= ram_address;
      last_data_q <= ram_data;
    end
  end

endmodule

`default_nettype wire
